// File: rtl/sample_scheduler.sv
// Round-robin scheduler that shares one threshold unit between three sample channels.
// Grants a channel, launches the threshold evaluation and records the result or aborts on timeout.
module sample_scheduler #(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              update_clk,
   input  logic              rst_n,
   input  logic [2:0]        req,
   input  logic [DATA_W-1:0] data_x,
   input  logic [DATA_W-1:0] data_y,
   input  logic [DATA_W-1:0] data_z,
   output logic [2:0]        ack,
   output logic [DATA_W-1:0] thr_data,
   output logic              thr_start,
   input  logic              thr_done,
   input  logic              thr_val,
   output logic [2:0]        flags,
   output logic              flags_valid,
   output logic              busy,
   output logic              timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [1:0]        rr;
   logic [1:0]        chan;
   logic [CNT_W-1:0]  cnt;
   logic              grant_any;
   logic [1:0]        grant_idx;
   logic [DATA_W-1:0] grant_data;

   function automatic logic [1:0] wrap3(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

   // Lowest search offset from rr wins, so the loop runs backwards and the last hit sticks.
   always_comb begin
      logic [1:0] cand;
      grant_any = 1'b0;
      grant_idx = rr;
      cand      = rr;
      for (int j = 2; j >= 0; j--) begin
         cand = wrap3(3'(rr) + 3'(j));
         if (req[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      case (grant_idx)
         2'd1:    grant_data = data_y;
         2'd2:    grant_data = data_z;
         default: grant_data = data_x;
      endcase
   end

   always_ff @(posedge update_clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_any) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (thr_done || cnt == CNT_LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Pulses default low each cycle; a completed result takes priority over the timeout abort.
   always_ff @(posedge update_clk or negedge rst_n) begin
      if (!rst_n) begin
         rr          <= 2'd0;
         chan        <= 2'd0;
         cnt         <= '0;
         ack         <= 3'b000;
         thr_data    <= '0;
         thr_start   <= 1'b0;
         flags       <= 3'b000;
         flags_valid <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         ack         <= 3'b000;
         thr_start   <= 1'b0;
         flags_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  chan     <= grant_idx;
                  thr_data <= grant_data;
                  ack      <= 3'b001 << grant_idx;
               end
            end
            ISSUE: begin
               thr_start <= 1'b1;
               cnt       <= '0;
            end
            WAIT: begin
               if (thr_done) begin
                  flags[chan] <= thr_val;
                  flags_valid <= 1'b1;
                  rr          <= wrap3(3'(chan) + 3'd1);
               end else if (cnt == CNT_LAST) begin
                  timeout_err <= 1'b1;
                  rr          <= wrap3(3'(chan) + 3'd1);
                  cnt         <= cnt + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
